data_path: RTL and testbench
============================

# data_path

8-bit register/bus datapath driven by `control_unit`. It holds IR, MAR, PC, A, B and CCR, plus the two bus multiplexers and the ALU. It returns `IR` and `CCR_Result` to the control unit, drives `address` and `to_memory` to the memory block, and receives `from_memory`. Every register is loaded on a clock edge under a control-unit strobe; all bus and ALU paths are combinational.

## Interface
- No parameters; all data paths are fixed at 8 bits.
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  reset; synchronous, active-high; clock clk.
- IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load  in  1 each  register strobes from `control_unit`.
- ALU_Sel  in  3  ALU operation select.
- BUS1_Sel  in  2  BUS1 source: 00 PC, 01 A, 10 B, 11 8'h00.
- BUS2_Sel  in  2  BUS2 source: 00 ALU_Result, 01 BUS1, 10 from_memory, 11 8'h00.
- from_memory  in  8  memory read data (combinational read).
- IR  out  8  instruction register.
- CCR_Result  out  4  {N,Z,V,C} register.
- address  out  8  MAR register contents.
- to_memory  out  8  BUS1 value; memory write data.

## Operation
- **Bus mapping**
  - BUS1 feeds `to_memory` and ALU operand X.
  - ALU operand Y is always the B register.
  - BUS2 feeds the D input of IR, MAR, PC, A and B.
- **ALU_Sel**
  - 000 add: X+Y.
  - 001 sub: X−Y.
  - 010 and: X&Y.
  - 011 or: X|Y.
  - 100 inc: X+1.
  - 101 dec: X−1.
  - 110 and 111: pass X.
  - The result is truncated to 8 bits.
- **Flags**, computed on every ALU result:
  - N = result[7].
  - Z = (result == 0).
  - V for add/inc: operands share a sign and the result sign differs.
  - V for sub/dec: operands differ in sign and the result sign differs from X.
  - C for add/inc: bit-8 carry out.
  - C for sub/dec: borrow (unsigned X < subtrahend).
  - Logic and pass ops: V = C = 0.
- **Register loads**
  - IR, MAR, A, B each load BUS2 when their strobe is 1; otherwise they hold.
  - CCR loads the ALU flags when CCR_Load = 1, independent of BUS2_Sel.
- **PC priority**
  - PC_Load = 1: PC ← BUS2.
  - Else PC_Inc = 1: PC ← PC+1, wrapping 8'hFF → 8'h00.
  - Else: hold.
  - PC_Load wins over PC_Inc when both are asserted.
- **Concurrent loads**
  - Several strobes in one cycle all capture the same BUS2 value.
  - A register that is both BUS2 source (via BUS1) and destination captures its pre-edge value as transformed. Example: A_Load with BUS1=A and ALU inc gives A ← A+1.
- **Reset**
  - rst = 1 at an edge clears IR, MAR, PC, A, B to 8'h00 and CCR to 4'h0.
  - Reset overrides all strobes.
  - Reset asserted mid-instruction abandons it; no partial load survives.

## Timing
- Register outputs (IR, CCR_Result, address) change only on a rising clk edge.
- `to_memory` and internal BUS2 follow select/register changes combinationally within the same cycle.
- Load latency is 1 cycle: a strobe asserted in cycle n produces the new value visible in cycle n+1.
- Memory read path: MAR loaded at edge n, so `address` is valid in cycle n+1. `from_memory` must be valid before edge n+1 for an IR/A/B/MAR load in cycle n+1.
  - This matches the control unit's 3-state fetch: MAR ← PC, then PC_Inc, then IR ← mem.
- Memory writes are the memory block's responsibility: with write_en=1 it captures `to_memory` at `address` on the edge.
- After reset release all outputs are 0, and the first fetch reads address 8'h00.
- No output is registered twice; there are no combinational loops, since BUS2 never feeds BUS1.

## Test plan
1. **Reset:** preload A=8'h55, PC=8'h10, then rst=1 for one edge → IR, MAR, PC, A, B = 0 and CCR_Result = 4'h0; rst together with A_Load → A stays 0.
2. **Fetch sequence:** PC=8'h00, from_memory=8'h86.
   - BUS2_Sel=01, BUS1_Sel=00, MAR_Load → address=8'h00.
   - PC_Inc → PC=8'h01.
   - BUS2_Sel=10, IR_Load → IR=8'h86.
3. **ADD with flags:**
   - A=8'h7F, B=8'h01, BUS1_Sel=01, BUS2_Sel=00, ALU 000, A_Load+CCR_Load → A=8'h80, CCR=4'b1010 (N=1, V=1).
   - Repeat with A=8'hFF, B=8'h01 → A=8'h00, CCR=4'b0101 (Z=1, C=1).
4. **SUB/DEC borrow:**
   - A=8'h00, B=8'h01, sub → A=8'hFF, CCR=4'b1001.
   - dec with A=8'h80 → A=8'h7F, CCR=4'b0010.
5. **PC priority and wrap:**
   - PC=8'hFF, PC_Inc → PC=8'h00.
   - PC_Load and PC_Inc together with BUS2=from_memory=8'h3C → PC=8'h3C, not 8'h3D.
6. **Store path:** A=8'hA5, BUS1_Sel=01 → to_memory=8'hA5 in the same cycle. With CCR_Load=0, CCR is unchanged; B_Load with BUS2_Sel=01 → B=8'hA5.

Source files
------------

// File: rtl/data_path.sv
// 8-bit register/bus datapath: IR, MAR, PC, A, B and CCR around two bus muxes
// and an ALU. Every register is loaded from BUS2 under control-unit strobes.
module data_path (
    input  logic       clk,
    input  logic       rst,
    input  logic       IR_Load_i,
    input  logic       MAR_Load_i,
    input  logic       PC_Load_i,
    input  logic       PC_Inc_i,
    input  logic       A_Load_i,
    input  logic       B_Load_i,
    input  logic       CCR_Load_i,
    input  logic [2:0] ALU_Sel_i,
    input  logic [1:0] BUS1_Sel_i,
    input  logic [1:0] BUS2_Sel_i,
    input  logic [7:0] from_memory_i,
    output logic [7:0] IR_o,
    output logic [3:0] CCR_Result_o,
    output logic [7:0] address_o,
    output logic [7:0] to_memory_o
);

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_INC  = 3'b100,
        ALU_DEC  = 3'b101,
        ALU_PASS = 3'b110,
        ALU_PSX  = 3'b111
    } alu_op_e;

    logic [7:0] ir_q,  ir_d;
    logic [7:0] mar_q, mar_d;
    logic [7:0] pc_q,  pc_d;
    logic [7:0] a_q,   a_d;
    logic [7:0] b_q,   b_d;
    logic [3:0] ccr_q, ccr_d;

    logic [7:0] bus1;
    logic [7:0] bus2;
    logic [7:0] opY;
    logic [8:0] addRes;
    logic [8:0] subRes;
    logic [7:0] aluResult;
    logic       flagV;
    logic       flagC;
    logic [3:0] aluFlags;
    alu_op_e    aluOp;

    assign aluOp = alu_op_e'(ALU_Sel_i);

    always_comb begin
        bus1 = 8'h00;
        unique case (BUS1_Sel_i)
            2'b00:   bus1 = pc_q;
            2'b01:   bus1 = a_q;
            2'b10:   bus1 = b_q;
            default: bus1 = 8'h00;
        endcase
    end

    // inc/dec reuse the add/sub datapath with a constant 1 as the second operand
    assign opY    = (aluOp == ALU_INC || aluOp == ALU_DEC) ? 8'h01 : b_q;
    assign addRes = {1'b0, bus1} + {1'b0, opY};
    assign subRes = {1'b0, bus1} - {1'b0, opY};

    always_comb begin
        aluResult = bus1;
        flagV     = 1'b0;
        flagC     = 1'b0;
        unique case (aluOp)
            ALU_ADD, ALU_INC: begin
                aluResult = addRes[7:0];
                flagC     = addRes[8];
                flagV     = (bus1[7] == opY[7]) && (addRes[7] != bus1[7]);
            end
            ALU_SUB, ALU_DEC: begin
                aluResult = subRes[7:0];
                flagC     = subRes[8];
                flagV     = (bus1[7] != opY[7]) && (subRes[7] != bus1[7]);
            end
            ALU_AND: aluResult = bus1 & b_q;
            ALU_OR:  aluResult = bus1 | b_q;
            default: aluResult = bus1;
        endcase
    end

    assign aluFlags = {aluResult[7], (aluResult == 8'h00), flagV, flagC};

    always_comb begin
        bus2 = 8'h00;
        unique case (BUS2_Sel_i)
            2'b00:   bus2 = aluResult;
            2'b01:   bus2 = bus1;
            2'b10:   bus2 = from_memory_i;
            default: bus2 = 8'h00;
        endcase
    end

    // PC_Load takes priority over PC_Inc
    always_comb begin
        ir_d  = IR_Load_i  ? bus2 : ir_q;
        mar_d = MAR_Load_i ? bus2 : mar_q;
        a_d   = A_Load_i   ? bus2 : a_q;
        b_d   = B_Load_i   ? bus2 : b_q;
        ccr_d = CCR_Load_i ? aluFlags : ccr_q;
        pc_d  = pc_q;
        if (PC_Load_i) begin
            pc_d = bus2;
        end else if (PC_Inc_i) begin
            pc_d = pc_q + 8'h01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q  <= 8'h00;
            mar_q <= 8'h00;
            pc_q  <= 8'h00;
            a_q   <= 8'h00;
            b_q   <= 8'h00;
            ccr_q <= 4'h0;
        end else begin
            ir_q  <= ir_d;
            mar_q <= mar_d;
            pc_q  <= pc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            ccr_q <= ccr_d;
        end
    end

    assign IR_o         = ir_q;
    assign CCR_Result_o = ccr_q;
    assign address_o    = mar_q;
    assign to_memory_o  = bus1;

endmodule

// File: tb/tb_data_path.sv
// Directed test of data_path: stimulus pushes hand-computed expectations into a
// queue that a negedge monitor drains and compares against the DUT outputs.
module tb_data_path;

    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_IR   = 7'b1000000;
    localparam logic [6:0] S_MAR  = 7'b0100000;
    localparam logic [6:0] S_PC   = 7'b0010000;
    localparam logic [6:0] S_INC  = 7'b0001000;
    localparam logic [6:0] S_A    = 7'b0000100;
    localparam logic [6:0] S_B    = 7'b0000010;
    localparam logic [6:0] S_CCR  = 7'b0000001;

    localparam logic [3:0] M_IR   = 4'b1000;
    localparam logic [3:0] M_CCR  = 4'b0100;
    localparam logic [3:0] M_ADDR = 4'b0010;
    localparam logic [3:0] M_TM   = 4'b0001;

    logic       clk;
    logic       rst;
    logic       irLoad, marLoad, pcLoad, pcInc, aLoad, bLoad, ccrLoad;
    logic [2:0] aluSel;
    logic [1:0] bus1Sel;
    logic [1:0] bus2Sel;
    logic [7:0] fromMemory;
    logic [7:0] irOut;
    logic [3:0] ccrOut;
    logic [7:0] addressOut;
    logic [7:0] toMemory;

    typedef struct {
        string      name;
        logic [3:0] mask;
        logic [7:0] ir;
        logic [3:0] ccr;
        logic [7:0] addr;
        logic [7:0] tm;
    } expect_t;

    expect_t scoreboard[$];
    int      checks = 0;
    int      errors = 0;

    data_path dut (
        .clk          (clk),
        .rst          (rst),
        .IR_Load_i    (irLoad),
        .MAR_Load_i   (marLoad),
        .PC_Load_i    (pcLoad),
        .PC_Inc_i     (pcInc),
        .A_Load_i     (aLoad),
        .B_Load_i     (bLoad),
        .CCR_Load_i   (ccrLoad),
        .ALU_Sel_i    (aluSel),
        .BUS1_Sel_i   (bus1Sel),
        .BUS2_Sel_i   (bus2Sel),
        .from_memory_i(fromMemory),
        .IR_o         (irOut),
        .CCR_Result_o (ccrOut),
        .address_o    (addressOut),
        .to_memory_o  (toMemory)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input expect_t e);
        if (e.mask[3]) begin
            checks++;
            if (irOut !== e.ir) begin
                errors++;
                $display("[TB] FAIL %s.IR got %02h expected %02h", e.name, irOut, e.ir);
            end
        end
        if (e.mask[2]) begin
            checks++;
            if (ccrOut !== e.ccr) begin
                errors++;
                $display("[TB] FAIL %s.CCR got %04b expected %04b", e.name, ccrOut, e.ccr);
            end
        end
        if (e.mask[1]) begin
            checks++;
            if (addressOut !== e.addr) begin
                errors++;
                $display("[TB] FAIL %s.address got %02h expected %02h", e.name, addressOut, e.addr);
            end
        end
        if (e.mask[0]) begin
            checks++;
            if (toMemory !== e.tm) begin
                errors++;
                $display("[TB] FAIL %s.to_memory got %02h expected %02h", e.name, toMemory, e.tm);
            end
        end
    endtask

    // Monitor: every expectation queued before this falling edge is checked now
    always @(negedge clk) begin
        while (scoreboard.size() > 0) begin
            checkOutput(scoreboard.pop_front());
        end
    end

    // Drives one cycle of control inputs; strobes and rst drop after the edge
    task automatic applyStimulus(input logic r, input logic [6:0] s, input logic [2:0] alu,
                                 input logic [1:0] b1, input logic [1:0] b2, input logic [7:0] mem);
        rst        = r;
        {irLoad, marLoad, pcLoad, pcInc, aLoad, bLoad, ccrLoad} = s;
        aluSel     = alu;
        bus1Sel    = b1;
        bus2Sel    = b2;
        fromMemory = mem;
        @(posedge clk);
        #1;
        rst = 1'b0;
        {irLoad, marLoad, pcLoad, pcInc, aLoad, bLoad, ccrLoad} = S_NONE;
    endtask

    task automatic expectOutput(input string name, input logic [3:0] mask, input logic [7:0] ir,
                                input logic [3:0] ccr, input logic [7:0] addr, input logic [7:0] tm);
        expect_t e;
        e.name = name;
        e.mask = mask;
        e.ir   = ir;
        e.ccr  = ccr;
        e.addr = addr;
        e.tm   = tm;
        scoreboard.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Selects a register onto BUS1 and expects it on to_memory this cycle
    task automatic observe(input logic [1:0] sel, input string name, input logic [7:0] v);
        bus1Sel = sel;
        expectOutput(name, M_TM, 8'h00, 4'h0, 8'h00, v);
        settle();
    endtask

    task automatic loadMem(input logic [6:0] s, input logic [7:0] v);
        applyStimulus(1'b0, s, 3'b000, 2'b00, 2'b10, v);
    endtask

    task automatic aluOp(input logic [2:0] alu);
        applyStimulus(1'b0, S_A | S_CCR, alu, 2'b01, 2'b00, 8'h00);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        {irLoad, marLoad, pcLoad, pcInc, aLoad, bLoad, ccrLoad} = S_NONE;
        aluSel = 3'b000; bus1Sel = 2'b00; bus2Sel = 2'b00; fromMemory = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expectOutput("reset_init", M_IR | M_CCR | M_ADDR | M_TM, 8'h00, 4'h0, 8'h00, 8'h00);
        settle();

        // Preload state, then reset with a competing A_Load
        loadMem(S_A, 8'h55);
        loadMem(S_PC, 8'h10);
        loadMem(S_IR, 8'h99);
        loadMem(S_MAR, 8'h77);
        loadMem(S_B, 8'h33);
        applyStimulus(1'b0, S_CCR, 3'b000, 2'b01, 2'b00, 8'h00);
        expectOutput("preload", M_IR | M_CCR | M_ADDR, 8'h99, 4'b1010, 8'h77, 8'h00);
        observe(2'b01, "pre_A", 8'h55);
        observe(2'b00, "pre_PC", 8'h10);
        applyStimulus(1'b1, S_A, 3'b000, 2'b00, 2'b10, 8'h55);
        expectOutput("rst_regs", M_IR | M_CCR | M_ADDR, 8'h00, 4'h0, 8'h00, 8'h00);
        observe(2'b01, "rst_A", 8'h00);
        observe(2'b00, "rst_PC", 8'h00);
        observe(2'b10, "rst_B", 8'h00);

        // Fetch: MAR <- PC, PC++, IR <- mem
        applyStimulus(1'b0, S_MAR, 3'b000, 2'b00, 2'b01, 8'h86);
        expectOutput("fetch_mar", M_ADDR, 8'h00, 4'h0, 8'h00, 8'h00);
        applyStimulus(1'b0, S_INC, 3'b000, 2'b00, 2'b01, 8'h86);
        observe(2'b00, "fetch_pc", 8'h01);
        applyStimulus(1'b0, S_IR, 3'b000, 2'b00, 2'b10, 8'h86);
        expectOutput("fetch_ir", M_IR, 8'h86, 4'h0, 8'h00, 8'h00);
        applyStimulus(1'b0, S_MAR, 3'b000, 2'b00, 2'b01, 8'h00);
        expectOutput("fetch_mar2", M_ADDR, 8'h00, 4'h0, 8'h01, 8'h00);
        settle();

        // ADD overflow and carry
        loadMem(S_A, 8'h7F);
        loadMem(S_B, 8'h01);
        aluOp(3'b000);
        expectOutput("add_ovf_ccr", M_CCR, 8'h00, 4'b1010, 8'h00, 8'h00);
        observe(2'b01, "add_ovf_A", 8'h80);
        loadMem(S_A, 8'hFF);
        aluOp(3'b000);
        expectOutput("add_carry_ccr", M_CCR, 8'h00, 4'b0101, 8'h00, 8'h00);
        observe(2'b01, "add_carry_A", 8'h00);

        // SUB borrow and DEC overflow
        loadMem(S_A, 8'h00);
        aluOp(3'b001);
        expectOutput("sub_ccr", M_CCR, 8'h00, 4'b1001, 8'h00, 8'h00);
        observe(2'b01, "sub_A", 8'hFF);
        loadMem(S_A, 8'h80);
        aluOp(3'b101);
        expectOutput("dec_ccr", M_CCR, 8'h00, 4'b0010, 8'h00, 8'h00);
        observe(2'b01, "dec_A", 8'h7F);

        // Logic, inc and pass
        loadMem(S_A, 8'hF0);
        loadMem(S_B, 8'h0F);
        aluOp(3'b011);
        expectOutput("or_ccr", M_CCR, 8'h00, 4'b1000, 8'h00, 8'h00);
        observe(2'b01, "or_A", 8'hFF);
        aluOp(3'b010);
        expectOutput("and_ccr", M_CCR, 8'h00, 4'b0000, 8'h00, 8'h00);
        observe(2'b01, "and_A", 8'h0F);
        loadMem(S_A, 8'h7F);
        aluOp(3'b100);
        expectOutput("inc_ccr", M_CCR, 8'h00, 4'b1010, 8'h00, 8'h00);
        observe(2'b01, "inc_A", 8'h80);
        loadMem(S_A, 8'h00);
        aluOp(3'b110);
        expectOutput("pass_ccr", M_CCR, 8'h00, 4'b0100, 8'h00, 8'h00);
        observe(2'b01, "pass_A", 8'h00);

        // PC wrap and load-over-increment priority
        loadMem(S_PC, 8'hFF);
        applyStimulus(1'b0, S_INC, 3'b000, 2'b00, 2'b01, 8'h00);
        observe(2'b00, "pc_wrap", 8'h00);
        loadMem(S_PC | S_INC, 8'h3C);
        observe(2'b00, "pc_prio", 8'h3C);

        // Store path, CCR hold, concurrent loads
        loadMem(S_A, 8'hA5);
        observe(2'b01, "store_tm", 8'hA5);
        applyStimulus(1'b0, S_B, 3'b000, 2'b01, 2'b01, 8'h00);
        expectOutput("ccr_hold", M_CCR, 8'h00, 4'b0100, 8'h00, 8'h00);
        observe(2'b10, "store_B", 8'hA5);
        loadMem(S_A | S_B | S_MAR, 8'h5A);
        expectOutput("multi_mar", M_ADDR, 8'h00, 4'h0, 8'h5A, 8'h00);
        observe(2'b01, "multi_A", 8'h5A);
        observe(2'b10, "multi_B", 8'h5A);

        settle();
        settle();
        if (scoreboard.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d pending expected 0", scoreboard.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
